mem_port_arbiter: RTL

//  Shares the single memory read/write port pair between the instruction-fetch (IF) and

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory signal bundle for mem_port_arbiter.
// slave = arbiter view, master = requesters plus memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid_i;
  logic              if_req_ready_o;
  logic [ADDR_W-1:0] if_req_addr_i;
  logic              if_resp_valid_o;
  logic [DATA_W-1:0] if_resp_data_o;
  logic              dm_req_valid_i;
  logic              dm_req_ready_o;
  logic              dm_req_we_i;
  logic [ADDR_W-1:0] dm_req_addr_i;
  logic [DATA_W-1:0] dm_req_wdata_i;
  logic              dm_resp_valid_o;
  logic [DATA_W-1:0] dm_resp_data_o;
  logic [ADDR_W-1:0] mem_rd_addr_o;
  logic [DATA_W-1:0] mem_rd_data_i;
  logic [ADDR_W-1:0] mem_wr_addr_o;
  logic [DATA_W-1:0] mem_wr_data_o;
  logic              mem_wr_enable_o;

  modport slave (
    input  if_req_valid_i, if_req_addr_i,
           dm_req_valid_i, dm_req_we_i, dm_req_addr_i, dm_req_wdata_i,
           mem_rd_data_i,
    output if_req_ready_o, if_resp_valid_o, if_resp_data_o,
           dm_req_ready_o, dm_resp_valid_o, dm_resp_data_o,
           mem_rd_addr_o, mem_wr_addr_o, mem_wr_data_o, mem_wr_enable_o
  );

  modport master (
    output if_req_valid_i, if_req_addr_i,
           dm_req_valid_i, dm_req_we_i, dm_req_addr_i, dm_req_wdata_i,
           mem_rd_data_i,
    input  if_req_ready_o, if_resp_valid_o, if_resp_data_o,
           dm_req_ready_o, dm_resp_valid_o, dm_resp_data_o,
           mem_rd_addr_o, mem_wr_addr_o, mem_wr_data_o, mem_wr_enable_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory read/write port pair between IF and DM
// requesters; one outstanding read with fixed latency, writes complete in the grant cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
)(
  input  logic             clk_i,
  input  logic             reset_ni,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {REQ_IF, REQ_DM} req_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  req_e              owner_q, owner_d;
  req_e              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_data_q, dm_data_d;

  logic resp_fire, grant_ok, dm_wins, if_ready, dm_ready, rd_grant, wr_grant;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      owner_q      <= REQ_IF;
      last_grant_q <= REQ_DM;
      rd_addr_q    <= '0;
      if_data_q    <= '0;
      dm_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rd_addr_q    <= rd_addr_d;
      if_data_q    <= if_data_d;
      dm_data_q    <= dm_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rd_addr_d    = rd_addr_q;
    if_data_d    = if_data_q;
    dm_data_d    = dm_data_q;

    resp_fire = (state_q == BUSY) && (lat_cnt_q == '0);
    // Grants are blocked while reset is held so ready never leaks out asynchronously.
    grant_ok  = reset_ni && ((state_q == IDLE) || resp_fire);
    dm_wins   = bus.dm_req_valid_i && (!bus.if_req_valid_i || (last_grant_q == REQ_IF));
    if_ready  = grant_ok && bus.if_req_valid_i && !dm_wins;
    dm_ready  = grant_ok && dm_wins;
    rd_grant  = if_ready || (dm_ready && !bus.dm_req_we_i);
    wr_grant  = dm_ready && bus.dm_req_we_i;

    if (state_q == BUSY && !resp_fire) lat_cnt_d = lat_cnt_q - CNT_W'(1);

    if (resp_fire) begin
      state_d = IDLE;
      if (owner_q == REQ_IF) if_data_d = bus.mem_rd_data_i;
      else                   dm_data_d = bus.mem_rd_data_i;
    end

    if (if_ready || dm_ready) last_grant_d = if_ready ? REQ_IF : REQ_DM;

    // A new read may start in the same cycle the previous one returns.
    if (rd_grant) begin
      state_d   = BUSY;
      lat_cnt_d = LAT_INIT;
      owner_d   = if_ready ? REQ_IF : REQ_DM;
      rd_addr_d = if_ready ? bus.if_req_addr_i : bus.dm_req_addr_i;
    end

    bus.if_req_ready_o  = if_ready;
    bus.dm_req_ready_o  = dm_ready;
    bus.if_resp_valid_o = resp_fire && (owner_q == REQ_IF);
    bus.dm_resp_valid_o = resp_fire && (owner_q == REQ_DM);
    bus.if_resp_data_o  = (resp_fire && owner_q == REQ_IF) ? bus.mem_rd_data_i : if_data_q;
    bus.dm_resp_data_o  = (resp_fire && owner_q == REQ_DM) ? bus.mem_rd_data_i : dm_data_q;
    bus.mem_rd_addr_o   = rd_grant ? rd_addr_d : rd_addr_q;
    bus.mem_wr_enable_o = wr_grant;
    bus.mem_wr_addr_o   = wr_grant ? bus.dm_req_addr_i  : '0;
    bus.mem_wr_data_o   = wr_grant ? bus.dm_req_wdata_i : '0;
  end
endmodule
